// File: rtl/pwm_duty_div.sv
// Sequential restoring divider for the duty-cycle computation.
// The first quotient bit is resolved in the start cycle from the input operands,
// so a DW-bit quotient takes DW clock edges and done pulses right after the last.
module pwm_duty_div #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W+6:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W+6:0] o_quotient
);
  localparam int DW = CNT_W + 7;
  localparam int CW = $clog2(DW + 1);

  logic [CNT_W-1:0] r_rem;
  logic [DW-1:0]    r_q;
  logic [CNT_W-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_rem_src;
  logic [DW-1:0]    w_q_src;
  logic [CNT_W-1:0] w_dvs;
  logic [CNT_W:0]   w_trial;
  logic             w_ge;
  logic [CNT_W-1:0] w_rem_nx;
  logic [DW-1:0]    w_q_nx;

  // One restoring step; operands come straight from the inputs on start.
  // The partial remainder stays below the divisor, so it fits in CNT_W bits.
  assign w_rem_src = i_start ? '0 : r_rem;
  assign w_q_src   = i_start ? i_dividend : r_q;
  assign w_dvs     = i_start ? i_divisor : r_dvs;
  assign w_trial   = {w_rem_src, w_q_src[DW-1]};
  assign w_ge      = (w_trial >= {1'b0, w_dvs});
  assign w_rem_nx  = w_ge ? CNT_W'(w_trial - {1'b0, w_dvs}) : w_trial[CNT_W-1:0];
  assign w_q_nx    = {w_q_src[DW-2:0], w_ge};

  // Iteration control: abort wins, then start, then the remaining DW-1 steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nx;
      r_q    <= w_q_nx;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(DW - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  // A zero divisor would otherwise produce all ones.
  assign o_quotient = (r_dvs == '0) ? '0 : r_q;
endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period, high time and duty percentage of pwm_in,
// with a no-edge timeout and overrun detection while the divider is busy.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 10000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       duty_pct,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_high,
  output logic             overrun,
  output logic             busy
);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W+6:0] DUTY_SCALE = (CNT_W+7)'(100);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_c;
  logic [CNT_W-1:0]       r_h;
  logic [TC_W-1:0]        r_tc;
  logic [CNT_W-1:0]       r_pp;
  logic [CNT_W-1:0]       r_hp;

  logic             w_s, w_rise, w_fall;
  logic             w_tmo, w_close, w_start, w_abort, w_publish;
  logic             w_busy, w_done;
  logic [CNT_W+6:0] w_dvd, w_quo;
  logic [7:0]       w_duty;
  logic [CNT_W-1:0] w_c_inc;

  // Input synchroniser plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  // An edge in the same cycle beats the timeout.
  assign w_tmo     = en && (r_state != ST_IDLE) && !(w_rise || w_fall) &&
                     (r_tc == TC_W'(TIMEOUT));
  assign w_close   = en && (r_state == ST_LOW) && w_rise;
  assign w_start   = w_close && !w_busy;
  assign w_abort   = !en || w_tmo;
  assign w_publish = w_done && !w_abort;
  assign w_dvd     = (CNT_W+7)'(r_h) * DUTY_SCALE;
  assign w_duty    = (w_quo > DUTY_SCALE) ? 8'd100 : w_quo[7:0];
  assign w_c_inc   = (r_c == '1) ? r_c : r_c + 1'b1;

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (w_dvd),
    .i_divisor  (r_c),
    .i_abort    (w_abort),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_quotient (w_quo)
  );

  assign busy = w_busy;

  // Capture FSM, period/timeout counters and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_c        <= '0;
      r_h        <= '0;
      r_tc       <= '0;
      r_pp       <= '0;
      r_hp       <= '0;
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      stuck_high <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid   <= w_publish;
      timeout <= w_tmo;
      if (w_publish) begin
        period     <= r_pp;
        high_time  <= r_hp;
        duty_pct   <= w_duty;
        stuck_high <= 1'b0;
      end
      // Operands that travel with the division in flight.
      if (w_start) begin
        r_pp <= r_c;
        r_hp <= r_h;
      end
      if (!en) begin
        r_state <= ST_IDLE;
        r_c     <= '0;
        r_tc    <= '0;
        overrun <= 1'b0;
      end else if (w_tmo) begin
        r_state    <= ST_ARM;
        r_tc       <= '0;
        period     <= '0;
        high_time  <= '0;
        duty_pct   <= w_s ? 8'd100 : 8'd0;
        stuck_high <= w_s;
      end else begin
        if ((r_state == ST_IDLE) || w_rise || w_fall) r_tc <= '0;
        else                                          r_tc <= r_tc + 1'b1;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_c     <= '0;
          end
          ST_ARM: begin
            if (w_rise) begin
              r_c     <= CNT_W'(1);
              r_state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            r_c <= w_c_inc;
            if (w_fall) begin
              r_h     <= r_c;
              r_state <= ST_LOW;
            end
          end
          default: begin
            if (w_rise) begin
              r_c     <= CNT_W'(1);
              r_state <= ST_HIGH;
              if (w_busy) overrun <= 1'b1;
            end else begin
              r_c <= w_c_inc;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture with an event-level reference model: every
// input edge is timestamped by the drive cycle and results/timeouts are
// predicted from those timestamps with plain arithmetic.
module tb_pwm_capture;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 1000;
  localparam int N       = CNT_W + 7;   // divider steps
  localparam int LAT     = CNT_W + 10;  // drive of closing rise -> visible valid
  localparam int INF     = 32'h7fffffff;

  logic             clk = 1'b0, reset = 1'b0, en = 1'b0, pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [7:0]       duty_pct;
  logic             valid, timeout, stuck_high, overrun, busy;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .en(en), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty_pct(duty_pct),
    .valid(valid), .timeout(timeout), .stuck_high(stuck_high),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; longint per; longint hi; longint duty; } res_t;
  res_t q[$];

  int n_chk = 0, n_fail = 0;
  bit in_rst = 1'b1;
  bit lvl = 1'b0;
  int phase = 0;  // 0 off, 1 waiting for rise, 2 high, 3 low
  int r0 = 0, f0 = 0, busy_free = 0, bstart = 1, bend = 0;
  int tmo_due = INF, ovr_at = -1;
  longint m_per = 0, m_hi = 0, m_duty = 0;
  bit m_stuck = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit ev = 1'b0, et = 1'b0;
    if (in_rst) begin
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_period", 64'(period), 64'd0);
      chk("rst_high", 64'(high_time), 64'd0);
      chk("rst_duty", 64'(duty_pct), 64'd0);
      chk("rst_flags", 64'({timeout, stuck_high, overrun, busy}), 64'd0);
      return;
    end
    if (cyc == tmo_due) begin
      et = 1'b1;
      while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
      m_per = 0; m_hi = 0; m_duty = lvl ? 100 : 0; m_stuck = lvl;
      phase = 1; busy_free = 0;
      if (bend > cyc - 1) bend = cyc - 1;
      tmo_due = cyc + TIMEOUT + 1;
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1;
      m_per = q[0].per; m_hi = q[0].hi; m_duty = q[0].duty; m_stuck = 1'b0;
      void'(q.pop_front());
    end
    chk("timeout", 64'(timeout), 64'(et));
    chk("valid", 64'(valid), 64'(ev));
    chk("period", 64'(period), 64'(m_per));
    chk("high_time", 64'(high_time), 64'(m_hi));
    chk("duty_pct", 64'(duty_pct), 64'(m_duty));
    chk("stuck_high", 64'(stuck_high), 64'(m_stuck));
    chk("overrun", 64'(overrun), 64'(ovr_at >= 0 && cyc >= ovr_at));
    chk("busy", 64'(busy), 64'(cyc >= bstart && cyc <= bend));
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pwm(input bit v);
    longint p, h, d;
    if (v == lvl) return;
    lvl = v; pwm_in = v;
    if (!en || in_rst) return;
    tmo_due = cyc + 4 + TIMEOUT;
    if (v) begin
      if (phase == 3) begin
        p = cyc - r0; h = f0 - r0; d = (h * 100) / p;
        if (d > 100) d = 100;
        if (cyc >= busy_free) begin
          q.push_back('{cyc + LAT, p, h, d});
          busy_free = cyc + N; bstart = cyc + 3; bend = cyc + N + 1;
        end else if (ovr_at < 0) begin
          ovr_at = cyc + 3;
        end
      end
      if (phase == 1 || phase == 3) begin r0 = cyc; phase = 2; end
    end else if (phase == 2) begin
      f0 = cyc; phase = 3;
    end
  endtask

  task automatic set_en(input bit v);
    en = v;
    if (!v) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      phase = 0; ovr_at = -1; busy_free = 0; tmo_due = INF;
      if (bend > cyc) bend = cyc;
    end else begin
      phase = 1; tmo_due = cyc + TIMEOUT + 2;
    end
  endtask

  task automatic pulse_train(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      set_pwm(1'b1); hold(hi);
      set_pwm(1'b0); hold(lo);
    end
  endtask

  initial begin
    hold(3);                       // reset state
    reset = 1'b1; in_rst = 1'b0;
    hold(3);
    set_en(1'b1); hold(5);

    // 30/70 steady stream, then duty change to 99/1
    pulse_train(30, 70, 5);
    pulse_train(30, 70, 2);
    pulse_train(99, 1, 3);
    // period-2 input: overruns while the divider is busy
    pulse_train(1, 1, 60);
    hold(60);
    set_en(1'b0); hold(5); set_en(1'b1); hold(5);

    // random widths
    for (int i = 0; i < 25; i++)
      pulse_train(int'($urandom_range(1, 80)), int'($urandom_range(1, 80)), 1);
    hold(60);

    // disable mid-division, re-enable with input still high
    pulse_train(30, 70, 2);
    set_pwm(1'b1); hold(10);
    set_en(1'b0); hold(6);
    set_en(1'b1); hold(5);
    set_pwm(1'b0); hold(20);
    pulse_train(30, 70, 3);

    // input stuck high -> repeated timeouts
    set_pwm(1'b1); hold(2300);
    set_pwm(1'b0); hold(20);

    // reset in the middle of a high phase
    pulse_train(30, 70, 2);
    set_pwm(1'b1); hold(12);
    reset = 1'b0; in_rst = 1'b1;
    q.delete(); m_per = 0; m_hi = 0; m_duty = 0; m_stuck = 1'b0;
    ovr_at = -1; bstart = 1; bend = 0; busy_free = 0; phase = 0; tmo_due = INF;
    hold(2);
    set_pwm(1'b0); hold(3);
    reset = 1'b1; in_rst = 1'b0;
    set_en(1'b1); hold(5);
    pulse_train(40, 60, 3);
    set_pwm(1'b1); hold(LAT + 5);

    // input stuck low -> timeout with duty 0
    set_pwm(1'b0); hold(TIMEOUT + 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
